// File: rtl/fir_pkg.sv
// Shared defaults and constant helpers for the FIR output stage:
// widths, saturation limits and the round-half-up bias.
package fir_pkg;

   localparam int FIR_OW    = 40;
   localparam int FIR_OUT_W = 16;
   localparam int FIR_SHIFT = 15;
   localparam int FIR_DECIM = 1;
   localparam int FIR_DEPTH = 4;
   localparam int SAT_CNT_W = 8;

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

   // Adding half an output LSB before the arithmetic shift gives round-half-up.
   function automatic longint round_bias(input int shift);
      return longint'(1) <<< (shift - 1);
   endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// Output stream toward the bus/DMA side: head sample, valid and ready.
interface fir_output_stage_if
   import fir_pkg::*;
#(
   parameter int OUT_W = FIR_OUT_W
) ();

   logic signed [OUT_W-1:0] o_data;
   logic                    o_valid;
   logic                    i_ready;

   modport master (
      output o_data,
      output o_valid,
      input  i_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      output i_ready
   );

endinterface

// File: rtl/fir_out_fifo.sv
// Small output FIFO with a registered head entry, occupancy count and
// full/empty flags; a push while full is ignored unless a pop frees a slot.
module fir_out_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_head;
   logic             w_doPush;
   logic             w_doPop;
   logic [AW-1:0]    w_rdNext;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == (AW+1)'(DEPTH));
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);
   assign w_rdNext = r_rdPtr + AW'(1);

   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= w_rdNext;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // The head register tracks the entry that will be at the read pointer after
   // this edge; an empty-to-nonempty push loads it straight from the input.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_head <= '0;
      end else if (w_doPop) begin
         if (r_count > (AW+1)'(1)) begin
            r_head <= r_mem[w_rdNext];
         end else if (w_doPush) begin
            r_head <= i_data;
         end
      end else if (w_doPush && o_empty) begin
         r_head <= i_data;
      end
   end

   assign o_data  = r_head;
   assign o_level = r_count;

endmodule

// File: rtl/fir_output_stage.sv
// Output stage after the FIR tap chain: decimate, round half-up, saturate to
// OUT_W and buffer in a FIFO; reports dropped samples and clip events.
module fir_output_stage
   import fir_pkg::*;
#(
   parameter int OW    = FIR_OW,
   parameter int OUT_W = FIR_OUT_W,
   parameter int SHIFT = FIR_SHIFT,
   parameter int DECIM = FIR_DECIM,
   parameter int DEPTH = FIR_DEPTH
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_ce,
   input  logic signed [OW-1:0]       i_acc,
   fir_output_stage_if.master         bus,
   input  logic                       i_clr,
   output logic                       o_overflow,
   output logic [SAT_CNT_W-1:0]       o_sat_cnt,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic signed [OW:0] C_BIAS = (OW+1)'(round_bias(SHIFT));
   localparam logic signed [OW:0] C_MAX  = (OW+1)'(sat_max(OUT_W));
   localparam logic signed [OW:0] C_MIN  = (OW+1)'(sat_min(OUT_W));
   localparam logic [SAT_CNT_W-1:0] C_SAT_TOP = '1;

   logic [CW-1:0]           r_decimCnt;
   logic                    w_keep;
   logic signed [OW:0]      r_stage1;
   logic                    r_v1;
   logic signed [OW:0]      w_shifted;
   logic                    w_clipHi;
   logic                    w_clipLo;
   logic signed [OUT_W-1:0] w_result;
   logic                    w_pop;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_drop;
   logic                    w_satEvent;
   logic                    r_overflow;
   logic [SAT_CNT_W-1:0]    r_satCnt;

   assign w_keep = i_ce && (r_decimCnt == '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_decimCnt <= '0;
      end else if (i_ce) begin
         r_decimCnt <= (r_decimCnt == CW'(DECIM - 1)) ? '0 : r_decimCnt + CW'(1);
      end
   end

   // One extra bit of headroom so adding the bias never wraps.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_stage1 <= '0;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= w_keep;
         if (w_keep) begin
            r_stage1 <= $signed({i_acc[OW-1], i_acc}) + C_BIAS;
         end
      end
   end

   assign w_shifted = r_stage1 >>> SHIFT;
   assign w_clipHi  = (w_shifted > C_MAX);
   assign w_clipLo  = (w_shifted < C_MIN);

   always_comb begin
      w_result = w_shifted[OUT_W-1:0];
      if (w_clipHi) begin
         w_result = C_MAX[OUT_W-1:0];
      end else if (w_clipLo) begin
         w_result = C_MIN[OUT_W-1:0];
      end
   end

   assign w_pop      = bus.o_valid && bus.i_ready;
   assign w_drop     = r_v1 && w_full && !w_pop;
   assign w_satEvent = r_v1 && (w_clipHi || w_clipLo);

   fir_out_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_push    (r_v1),
      .i_data    (w_result),
      .i_pop     (w_pop),
      .o_data    (bus.o_data),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_level   (o_level)
   );

   assign bus.o_valid = !w_empty;

   // A new event in the same cycle as a clear wins over the clear.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_overflow <= 1'b0;
         r_satCnt   <= '0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (i_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_satEvent) begin
            if (i_clr) begin
               r_satCnt <= SAT_CNT_W'(1);
            end else if (r_satCnt != C_SAT_TOP) begin
               r_satCnt <= r_satCnt + SAT_CNT_W'(1);
            end
         end else if (i_clr) begin
            r_satCnt <= '0;
         end
      end
   end

   assign o_overflow = r_overflow;
   assign o_sat_cnt  = r_satCnt;

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: two instances (DECIM=1 and DECIM=3) share stimulus
// and are compared against a queue-based arithmetic reference model.
module tb_fir_output_stage;

   localparam int OW    = 40;
   localparam int OUT_W = 16;
   localparam int SHIFT = 15;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce = 1'b0;
   logic          clr = 1'b0;
   logic          ready = 1'b0;
   logic [OW-1:0] acc = '0;
   logic          ovf1, ovf3;
   logic [7:0]    sat1, sat3;
   logic [2:0]    lvl1, lvl3;

   int n_checks = 0;
   int n_errors = 0;
   int got1[$];
   int got3[$];
   int exp1[$];
   int exp3[$];
   int m_ce3 = 0;
   int m_sat1 = 0;
   int m_sat3 = 0;

   always #5 clk = ~clk;

   fir_output_stage_if #(.OUT_W(OUT_W)) bus1 ();
   fir_output_stage_if #(.OUT_W(OUT_W)) bus3 ();
   assign bus1.i_ready = ready;
   assign bus3.i_ready = ready;

   fir_output_stage #(.OW(OW), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut1 (
      .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce), .i_acc(acc), .bus(bus1),
      .i_clr(clr), .o_overflow(ovf1), .o_sat_cnt(sat1), .o_level(lvl1));

   fir_output_stage #(.OW(OW), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) dut3 (
      .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce), .i_acc(acc), .bus(bus3),
      .i_clr(clr), .o_overflow(ovf3), .o_sat_cnt(sat3), .o_level(lvl3));

   // Record every accepted output word.
   always @(negedge clk) begin
      if (bus1.o_valid && bus1.i_ready) got1.push_back(int'(bus1.o_data));
      if (bus3.o_valid && bus3.i_ready) got3.push_back(int'(bus3.o_data));
   end

   // Reference: floor((a + 2^(SHIFT-1)) / 2^SHIFT), then clamp to OUT_W signed.
   function automatic int model_sample(input longint a, output bit clipped);
      longint q, s, div, lim;
      div = longint'(1) <<< SHIFT;
      lim = longint'(1) <<< (OUT_W - 1);
      q = a + div / 2;
      if (q >= 0) s = q / div;
      else        s = -((-q + div - 1) / div);
      clipped = 1'b0;
      if (s > lim - 1) begin s = lim - 1; clipped = 1'b1; end
      if (s < -lim)    begin s = -lim;    clipped = 1'b1; end
      return int'(s);
   endfunction

   function automatic longint rand_acc();
      longint r, mag;
      int sh;
      sh  = $urandom_range(1, OW - 2);
      r   = {$urandom, $urandom};
      mag = r & ((longint'(1) <<< sh) - 1);
      return ($urandom_range(0, 1) != 0) ? -mag : mag;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      ce = 1'b0; clr = 1'b0; ready = 1'b0; acc = '0;
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      got1.delete(); got3.delete(); exp1.delete(); exp3.delete();
      m_ce3 = 0; m_sat1 = 0; m_sat3 = 0;
   endtask

   task automatic send(input longint a);
      bit c;
      int s;
      ce  = 1'b1;
      acc = a[OW-1:0];
      s   = model_sample(a, c);
      exp1.push_back(s);
      if (c) m_sat1++;
      if (m_ce3 % 3 == 0) begin
         exp3.push_back(s);
         if (c) m_sat3++;
      end
      m_ce3++;
      tick();
      ce = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      n_checks += 5;
      if (bus1.o_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus1.o_valid); end
      if (bus1.o_data !== 16'sd0) begin n_errors++; $display("[TB] FAIL reset_data: got %0d want 0", bus1.o_data); end
      if (lvl1 !== 3'd0) begin n_errors++; $display("[TB] FAIL reset_level: got %0d want 0", lvl1); end
      if (ovf1 !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_overflow: got %b want 0", ovf1); end
      if (sat1 !== 8'd0) begin n_errors++; $display("[TB] FAIL reset_satcnt: got %0d want 0", sat1); end
      apply_reset();
   endtask

   task automatic test_rounding();
      apply_reset();
      ready = 1'b1;
      send(32768);
      n_checks++;
      if (bus1.o_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL latency_early: valid %b want 0", bus1.o_valid); end
      send(16384);
      n_checks++;
      if (bus1.o_valid !== 1'b1 || bus1.o_data !== 16'sd1) begin
         n_errors++; $display("[TB] FAIL latency_first: valid %b data %0d want 1/1", bus1.o_valid, bus1.o_data);
      end
      send(-16384);
      send(-16385);
      repeat (4) tick();
      n_checks++;
      if (got1.size() !== exp1.size()) begin n_errors++; $display("[TB] FAIL round_count: got %0d want %0d", got1.size(), exp1.size()); end
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         n_checks++;
         if (got1[i] !== exp1[i]) begin n_errors++; $display("[TB] FAIL round_data[%0d]: got %0d want %0d", i, got1[i], exp1[i]); end
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      ready = 1'b1;
      send(longint'(1) <<< 31);
      send(-(longint'(1) <<< 31) - 65536);
      repeat (4) tick();
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         n_checks++;
         if (got1[i] !== exp1[i]) begin n_errors++; $display("[TB] FAIL sat_data[%0d]: got %0d want %0d", i, got1[i], exp1[i]); end
      end
      n_checks += 3;
      if (got1.size() !== 2) begin n_errors++; $display("[TB] FAIL sat_count_out: got %0d want 2", got1.size()); end
      if (int'(sat1) !== m_sat1) begin n_errors++; $display("[TB] FAIL sat_cnt1: got %0d want %0d", sat1, m_sat1); end
      if (int'(sat3) !== m_sat3) begin n_errors++; $display("[TB] FAIL sat_cnt3: got %0d want %0d", sat3, m_sat3); end
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (sat1 !== 8'd0) begin n_errors++; $display("[TB] FAIL sat_clr: got %0d want 0", sat1); end
      // Clip arriving on the same edge as a clear.
      ce = 1'b1; acc = 40'sd1 <<< 31; tick(); ce = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (sat1 !== 8'd1) begin n_errors++; $display("[TB] FAIL sat_clr_collide: got %0d want 1", sat1); end
   endtask

   task automatic test_sat_hold();
      apply_reset();
      ready = 1'b1;
      for (int i = 0; i < 260; i++) send((longint'(1) <<< 37) + longint'(i));
      repeat (3) tick();
      n_checks++;
      if (sat1 !== 8'd255) begin n_errors++; $display("[TB] FAIL sat_hold: got %0d want 255 (model %0d)", sat1, m_sat1); end
   endtask

   task automatic test_decimation();
      apply_reset();
      ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         send(longint'(k) * 32768);
         if (k == 3) repeat (2) tick();
      end
      repeat (4) tick();
      n_checks++;
      if (got3.size() !== exp3.size()) begin n_errors++; $display("[TB] FAIL decim_count: got %0d want %0d", got3.size(), exp3.size()); end
      for (int i = 0; i < exp3.size() && i < got3.size(); i++) begin
         n_checks++;
         if (got3[i] !== exp3[i]) begin n_errors++; $display("[TB] FAIL decim_data[%0d]: got %0d want %0d", i, got3[i], exp3[i]); end
      end
   endtask

   task automatic test_overflow();
      int exp[$];
      apply_reset();
      for (int k = 1; k <= 5; k++) send(longint'(k) * 32768);
      repeat (3) tick();
      n_checks += 3;
      if (lvl1 !== 3'd4) begin n_errors++; $display("[TB] FAIL ovf_level: got %0d want 4", lvl1); end
      if (ovf1 !== 1'b1) begin n_errors++; $display("[TB] FAIL ovf_flag: got %b want 1", ovf1); end
      if (ovf3 !== 1'b0) begin n_errors++; $display("[TB] FAIL ovf_flag3: got %b want 0", ovf3); end
      exp = exp1;
      while (exp.size() > DEPTH) void'(exp.pop_back());
      ready = 1'b1; repeat (8) tick(); ready = 1'b0;
      n_checks += 2;
      if (got1.size() !== exp.size()) begin n_errors++; $display("[TB] FAIL ovf_drain_count: got %0d want %0d", got1.size(), exp.size()); end
      if (lvl1 !== 3'd0) begin n_errors++; $display("[TB] FAIL ovf_drain_level: got %0d want 0", lvl1); end
      for (int i = 0; i < exp.size() && i < got1.size(); i++) begin
         n_checks++;
         if (got1[i] !== exp[i]) begin n_errors++; $display("[TB] FAIL ovf_data[%0d]: got %0d want %0d", i, got1[i], exp[i]); end
      end
      clr = 1'b1; tick(); clr = 1'b0;
      n_checks++;
      if (ovf1 !== 1'b0) begin n_errors++; $display("[TB] FAIL ovf_clr: got %b want 0", ovf1); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int k = 1; k <= 4; k++) send(longint'(k) * 32768);
      repeat (2) tick();
      n_checks++;
      if (lvl1 !== 3'd4) begin n_errors++; $display("[TB] FAIL b2b_full: got %0d want 4", lvl1); end
      // Fifth sample reaches the full FIFO on the same edge as a pop.
      send(5 * 32768);
      ready = 1'b1; tick(); ready = 1'b0;
      n_checks += 2;
      if (lvl1 !== 3'd4) begin n_errors++; $display("[TB] FAIL b2b_level: got %0d want 4", lvl1); end
      if (ovf1 !== 1'b0) begin n_errors++; $display("[TB] FAIL b2b_overflow: got %b want 0", ovf1); end
      ready = 1'b1; repeat (8) tick(); ready = 1'b0;
      n_checks++;
      if (got1.size() !== exp1.size()) begin n_errors++; $display("[TB] FAIL b2b_count: got %0d want %0d", got1.size(), exp1.size()); end
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         n_checks++;
         if (got1[i] !== exp1[i]) begin n_errors++; $display("[TB] FAIL b2b_data[%0d]: got %0d want %0d", i, got1[i], exp1[i]); end
      end
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      ready = 1'b1;
      send(32768); send(2 * 32768);
      repeat (3) tick();
      ready = 1'b0;
      for (int k = 3; k <= 5; k++) send(longint'(k) * 32768);
      repeat (2) tick();
      n_checks++;
      if (lvl1 !== 3'd3) begin n_errors++; $display("[TB] FAIL mid_level_pre: got %0d want 3", lvl1); end
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      n_checks += 3;
      if (bus1.o_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_async_valid: got %b want 0", bus1.o_valid); end
      if (lvl1 !== 3'd0) begin n_errors++; $display("[TB] FAIL mid_async_level: got %0d want 0", lvl1); end
      if (lvl3 !== 3'd0) begin n_errors++; $display("[TB] FAIL mid_async_level3: got %0d want 0", lvl3); end
      tick();
      reset_n = 1'b1;
      got1.delete(); got3.delete();
      ready = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (lvl1 !== 3'd0 || got1.size() !== 0) begin n_errors++; $display("[TB] FAIL mid_no_partial: level %0d outputs %0d want 0/0", lvl1, got1.size()); end
      send(32768);
      n_checks++;
      if (bus1.o_valid !== 1'b0 || bus3.o_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_latency_early: valid %b/%b want 0/0", bus1.o_valid, bus3.o_valid); end
      tick();
      n_checks += 2;
      if (bus1.o_valid !== 1'b1 || bus1.o_data !== 16'sd1) begin n_errors++; $display("[TB] FAIL mid_restart1: valid %b data %0d want 1/1", bus1.o_valid, bus1.o_data); end
      if (bus3.o_valid !== 1'b1 || bus3.o_data !== 16'sd1) begin n_errors++; $display("[TB] FAIL mid_phase3: valid %b data %0d want 1/1", bus3.o_valid, bus3.o_data); end
   endtask

   task automatic test_random();
      apply_reset();
      ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) < 7) send(rand_acc());
         else tick();
      end
      repeat (4) tick();
      n_checks += 5;
      if (got1.size() !== exp1.size()) begin n_errors++; $display("[TB] FAIL rnd_count1: got %0d want %0d", got1.size(), exp1.size()); end
      if (got3.size() !== exp3.size()) begin n_errors++; $display("[TB] FAIL rnd_count3: got %0d want %0d", got3.size(), exp3.size()); end
      if (int'(sat1) !== ((m_sat1 > 255) ? 255 : m_sat1)) begin n_errors++; $display("[TB] FAIL rnd_sat1: got %0d want %0d", sat1, m_sat1); end
      if (int'(sat3) !== ((m_sat3 > 255) ? 255 : m_sat3)) begin n_errors++; $display("[TB] FAIL rnd_sat3: got %0d want %0d", sat3, m_sat3); end
      if (ovf1 !== 1'b0) begin n_errors++; $display("[TB] FAIL rnd_overflow: got %b want 0", ovf1); end
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         n_checks++;
         if (got1[i] !== exp1[i]) begin n_errors++; $display("[TB] FAIL rnd_data1[%0d]: got %0d want %0d", i, got1[i], exp1[i]); end
      end
      for (int i = 0; i < exp3.size() && i < got3.size(); i++) begin
         n_checks++;
         if (got3[i] !== exp3[i]) begin n_errors++; $display("[TB] FAIL rnd_data3[%0d]: got %0d want %0d", i, got3[i], exp3[i]); end
      end
   endtask

   initial begin
      $display("[TB] starting fir_output_stage bench");
      test_reset();
      test_rounding();
      test_saturation();
      test_sat_hold();
      test_decimation();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fir_output_stage.md
Name: fir_output_stage

Overview:
- Downstream neighbour of the FIR tap chain. Consumes the final tap's accumulator result on each clock-enable, decimates by a fixed factor, rounds and saturates to output width, and buffers results in a small FIFO with a valid/ready interface toward the bus/DMA side.
- Decouples the free-running FIR chain from a consumer that can stall; reports lost samples and saturation events.

Parameters:
- OW, 40, accumulator width from the tap chain (IW+TW+8)
- OUT_W, 16, output sample width
- SHIFT, 15, LSBs dropped by rounding (1 ≤ SHIFT ≤ OW-OUT_W)
- DECIM, 1, decimation factor (≥1); every DECIM-th accepted sample is kept
- DEPTH, 4, output FIFO depth (power of two, ≥2)

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  asynchronous active-low reset
- i_ce  input  1  sample strobe, same strobe that drives the tap chain
- i_acc  input  OW  signed accumulator from the last tap, sampled when i_ce=1
- o_data  output  OUT_W  signed FIFO head sample
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer accepts o_data when o_valid&&i_ready
- i_clr  input  1  synchronous clear of o_overflow and o_sat_cnt
- o_overflow  output  1  sticky: a kept sample was dropped because FIFO full
- o_sat_cnt  output  8  saturating count of clipped samples
- o_level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): decimation counter=0, pipeline valid bits=0, FIFO empty, o_valid=0, o_data=0, o_overflow=0, o_sat_cnt=0, o_level=0.
- Decimation: counter advances only on i_ce; a sample is kept when counter==0; counter wraps DECIM-1→0. DECIM=1 keeps every sample.
- Stage 1 (cycle N, i_ce=1 and kept): r1 <= (sign-extended i_acc to OW+1) + 2^(SHIFT-1); v1 <= 1. Otherwise v1 <= 0. Round half-up (toward +inf at ties).
- Stage 2 (cycle N+1): s = r1 >>> SHIFT (arithmetic). If s > 2^(OUT_W-1)-1, clip to max; if s < -2^(OUT_W-1), clip to min; either clip increments o_sat_cnt (holds at 255). Result is pushed to FIFO when v1=1.
- Latency: kept sample at i_ce edge N appears at o_data / o_valid=1 after edge N+2 if FIFO was empty.
- FIFO: pop when o_valid&&i_ready. Push when full and no pop in the same cycle -> sample dropped, o_overflow <= 1. Push and pop in the same cycle while full -> both occur, level unchanged, no overflow. Push and pop in the same cycle while empty -> push only (no bypass).
- o_data is the registered head entry; stable while o_valid=1 and i_ready=0.
- i_clr: clears o_overflow and o_sat_cnt next edge. An overflow or clip in the same cycle wins (flag set, counter=1).
- Reset mid-operation discards pipeline and FIFO contents; no partial output after release.
- i_ce gaps: pipeline holds nothing (v1=0); FIFO contents unaffected.

Decomposition:
- Package fir_pkg: OW/OUT_W/SHIFT defaults, sat_max/sat_min constant functions, and a rounding-bias constant.
- One sub-module: fir_out_fifo (DEPTH × OUT_W, registered head, level output, push/pop/full/empty). Round/saturate and decimation stay in the top.

Test Plan:
- DECIM=1, i_ce pulses with i_acc=32768, 16384, -16384, -16385, i_ready=1 -> o_data 1, 1, 0, -1 in order; first o_valid 2 cycles after first i_ce.
- i_acc=2^31, then -2^31-65536 -> o_data 32767, -32768; o_sat_cnt=2; i_clr -> o_sat_cnt=0.
- DECIM=3, i_acc = k*32768 for k=1..7 -> outputs 1, 4, 7 only.
- i_ready=0, push 5 samples 1..5 (DEPTH=4) -> o_level=4, o_overflow=1; drain -> 1, 2, 3, 4.
- FIFO full, i_ready=1 and a new push on the same cycle -> level stays 4, o_overflow stays 0, order preserved.
- Assert i_reset_n=0 asynchronously mid-stream with 3 entries queued -> o_valid=0 and o_level=0 immediately; after release, next i_ce of 32768 yields 1 with 2-cycle latency and the decimation phase restarts at 0.
